fetch_queue: RTL and testbench

- Small instruction queue directly downstream of the fetch stage.
- Buffers (PC, instruction) pairs coming from the fetch/instruction-memory path and hands them to decode with a valid/ready handshake.
- Decouples fetch from decode stalls: in_ready_F acts as the fetch-stage stall.
- A taken branch (flush_F) discards every buffered and in-flight entry.

---
 rtl/fetch_queue_pkg.sv | 18 +
 rtl/fetch_queue_mem.sv | 34 +++
 rtl/fetch_queue.sv | 122 ++++++++++++
 tb/tb_fetch_queue.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg: shared defaults and types for the fetch queue.
//   FQ_N / FQ_W / FQ_DEPTH : default PC width, instruction width, entry count
//   fq_entry_t             : one buffered (PC, instruction) pair
//   NOP_INSTR              : instruction value shown on the head when idle
package fetch_queue_pkg;

  localparam int FQ_N     = 64;
  localparam int FQ_W     = 32;
  localparam int FQ_DEPTH = 4;

  typedef struct packed {
    logic [FQ_N-1:0] pc;
    logic [FQ_W-1:0] instr;
  } fq_entry_t;

  localparam logic [FQ_W-1:0] NOP_INSTR = '0;

endpackage

// File: rtl/fetch_queue_mem.sv
// fetch_queue_mem: DEPTH x WIDTH register array for the fetch queue.
//   clk_i   : clock, write on rising edge
//   we_i    : write enable
//   waddr_i : write slot
//   wdata_i : write data ({pc, instr})
//   raddr_i : read slot (asynchronous read)
//   rdata_o : contents of raddr_i
// Storage is deliberately not reset; validity is tracked by the pointers.
module fetch_queue_mem
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH,
  parameter int WIDTH = FQ_N + FQ_W,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: instruction queue between fetch and decode.
//   clk          : clock
//   reset        : asynchronous active-low reset
//   flush_F      : taken-branch flush, drops every entry (priority over push/pop)
//   in_valid_F   : fetch presents an entry
//   in_ready_F   : queue can accept (acts as the fetch stall)
//   in_pc_F      : PC of the presented entry
//   in_instr_F   : instruction word of the presented entry
//   out_valid_D  : head entry valid toward decode
//   out_ready_D  : decode takes the head entry
//   out_pc_D     : head PC (0 when not valid)
//   out_instr_D  : head instruction (NOP_INSTR when not valid)
//   count_o      : current occupancy
// Build option: define FETCH_QUEUE_BYPASS_EN to forward an incoming entry to
// the head in the same cycle when the queue is empty.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int N     = FQ_N,
  parameter int W     = FQ_W,
  parameter int DEPTH = FQ_DEPTH,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush_F,
  input  logic          in_valid_F,
  output logic          in_ready_F,
  input  logic [N-1:0]  in_pc_F,
  input  logic [W-1:0]  in_instr_F,
  output logic          out_valid_D,
  input  logic          out_ready_D,
  output logic [N-1:0]  out_pc_D,
  output logic [W-1:0]  out_instr_D,
  output logic [CW-1:0] count_o
);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]  count_q, count_d;

  logic           q_valid;
  logic           bypass;
  logic           pop;
  logic           q_pop;
  logic           push;
  logic [N+W-1:0] rd_data;
  logic [N-1:0]   head_pc;
  logic [W-1:0]   head_instr;

  fetch_queue_mem #(
    .DEPTH (DEPTH),
    .WIDTH (N + W)
  ) u_mem (
    .clk_i   (clk),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i ({in_pc_F, in_instr_F}),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_data)
  );

  // Gating with reset keeps the handshake dead while reset is held, even
  // though the registered state is already cleared asynchronously.
  assign in_ready_F = reset && (count_q < FULL_CNT);
  assign q_valid    = reset && (count_q != '0) && !flush_F;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass = reset && (count_q == '0) && in_valid_F && !flush_F;
`else
  assign bypass = 1'b0;
`endif

  assign out_valid_D = q_valid || bypass;
  assign pop         = out_valid_D && out_ready_D;
  // Only a pop of a stored entry moves rd_ptr; a bypassed pop touches nothing.
  assign q_pop       = pop && q_valid;
  // A bypassed entry consumed this cycle is never written.
  assign push        = in_valid_F && in_ready_F && !flush_F && !(bypass && out_ready_D);

  assign head_pc    = bypass ? in_pc_F    : rd_data[N+W-1:W];
  assign head_instr = bypass ? in_instr_F : rd_data[W-1:0];

  assign out_pc_D    = out_valid_D ? head_pc    : '0;
  assign out_instr_D = out_valid_D ? head_instr : W'(NOP_INSTR);
  assign count_o     = count_q;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_F) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push)  wr_ptr_d = wr_ptr_q + PW'(1);
      if (q_pop) rd_ptr_d = rd_ptr_q + PW'(1);
      unique case ({push, q_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int N     = FQ_N;
  localparam int W     = FQ_W;
  localparam int DEPTH = FQ_DEPTH;
  localparam int CW    = $clog2(DEPTH) + 1;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          flush_F = 1'b0;
  logic          in_valid_F = 1'b0;
  logic          in_ready_F;
  logic [N-1:0]  in_pc_F = '0;
  logic [W-1:0]  in_instr_F = '0;
  logic          out_valid_D;
  logic          out_ready_D = 1'b0;
  logic [N-1:0]  out_pc_D;
  logic [W-1:0]  out_instr_D;
  logic [CW-1:0] count_o;

  int checks = 0;
  int errors = 0;

  // Entries accepted and not yet delivered, oldest first.
  fq_entry_t exp_q[$];

  always #5 clk = ~clk;

  fetch_queue dut (
    .clk         (clk),
    .reset       (reset),
    .flush_F     (flush_F),
    .in_valid_F  (in_valid_F),
    .in_ready_F  (in_ready_F),
    .in_pc_F     (in_pc_F),
    .in_instr_F  (in_instr_F),
    .out_valid_D (out_valid_D),
    .out_ready_D (out_ready_D),
    .out_pc_D    (out_pc_D),
    .out_instr_D (out_instr_D),
    .count_o     (count_o)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor / scoreboard: mid-cycle, inputs and outputs are stable.
  always @(negedge clk) begin : monitor
    int        sz;
    logic      byp;
    logic      ev;
    fq_entry_t inc;
    fq_entry_t hd;
    if (!reset) begin
      check("rst_out_valid", out_valid_D, 0);
      check("rst_in_ready", in_ready_F, 0);
      check("rst_count", count_o, 0);
      check("rst_out_pc", out_pc_D, 0);
      check("rst_out_instr", out_instr_D, 0);
      exp_q.delete();
    end else begin
      sz        = exp_q.size();
      inc.pc    = in_pc_F;
      inc.instr = in_instr_F;
      byp = BYP && (sz == 0) && in_valid_F && !flush_F;
      ev  = ((sz != 0) || byp) && !flush_F;
      check("count", count_o, sz);
      check("in_ready", in_ready_F, sz < DEPTH);
      check("out_valid", out_valid_D, ev);
      if (!ev) begin
        check("idle_pc", out_pc_D, 0);
        check("idle_instr", out_instr_D, 0);
      end
      if (flush_F) begin
        exp_q.delete();
      end else begin
        if (in_valid_F && sz < DEPTH) exp_q.push_back(inc);
        if (ev && out_ready_D) begin
          hd = exp_q.pop_front();
          check("head_pc", out_pc_D, hd.pc);
          check("head_instr", out_instr_D, hd.instr);
        end
      end
    end
  end

  // One cycle of stimulus, starting and ending 1 time unit after a rising edge.
  task automatic step(input logic v, input logic [N-1:0] pc, input logic rdy,
                      input logic fl, output logic took);
    in_valid_F  = v;
    in_pc_F     = pc;
    in_instr_F  = $urandom;
    out_ready_D = rdy;
    flush_F     = fl;
    @(negedge clk);
    took = v && in_ready_F && !fl;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    logic t;
    repeat (DEPTH + 2) step(1'b0, '0, 1'b1, 1'b0, t);
  endtask

  initial begin : timeout
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin : driver
    logic         took;
    logic [N-1:0] pc;
    reset = 1'b1;
    #2 reset = 1'b0;

    // Reset held with fetch presenting an entry.
    in_valid_F = 1'b1;
    in_pc_F    = 64'h999;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    step(1'b0, '0, 1'b1, 1'b0, took);
    step(1'b0, '0, 1'b1, 1'b0, took);

    // Fill to full, 0x10 held, then drain in order.
    for (int i = 0; i < 4; i++) step(1'b1, 64'(i * 4), 1'b0, 1'b0, took);
    pc = 64'h10;
    step(1'b1, pc, 1'b0, 1'b0, took);
    check("held_when_full", took, 0);
    for (int k = 0; k < 20 && !took; k++) step(1'b1, pc, 1'b1, 1'b0, took);
    check("accept_0x10", took, 1);
    drain();

    // Streaming with pointer wrap.
    for (int i = 0; i < 20; i++) step(1'b1, 64'h200 + 64'(4 * i), 1'b1, 1'b0, took);
    drain();

    // Flush with 3 queued and an incoming 0x40.
    for (int i = 0; i < 3; i++) step(1'b1, 64'h300 + 64'(4 * i), 1'b0, 1'b0, took);
    step(1'b1, 64'h40, 1'b0, 1'b1, took);
    check("flush_drops_incoming", took, 0);
    step(1'b1, 64'h100, 1'b0, 1'b0, took);
    drain();

    // Push+pop at count 2, then pop at full refuses push.
    for (int i = 0; i < 2; i++) step(1'b1, 64'h400 + 64'(4 * i), 1'b0, 1'b0, took);
    step(1'b1, 64'h408, 1'b1, 1'b0, took);
    for (int i = 0; i < 2; i++) step(1'b1, 64'h40C + 64'(4 * i), 1'b0, 1'b0, took);
    step(1'b1, 64'h414, 1'b1, 1'b0, took);
    check("full_pop_refuses_push", took, 0);
    drain();

    // Asynchronous reset mid-stream with count 3.
    for (int i = 0; i < 3; i++) step(1'b1, 64'h600 + 64'(4 * i), 1'b0, 1'b0, took);
    in_valid_F  = 1'b1;
    out_ready_D = 1'b1;
    reset       = 1'b0;
    #1;
    check("async_rst_valid", out_valid_D, 0);
    check("async_rst_count", count_o, 0);
    check("async_rst_ready", in_ready_F, 0);
    check("async_rst_pc", out_pc_D, 0);
    in_valid_F = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    step(1'b0, '0, 1'b1, 1'b0, took);

    // Empty queue, push with decode ready.
    step(1'b1, 64'h500, 1'b1, 1'b0, took);
    check("empty_push_taken", took, 1);
    drain();

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 9) < 7, {$urandom, $urandom}, $urandom_range(0, 9) < 6,
           $urandom_range(0, 19) == 0, took);
    end
    drain();
    check("final_count", count_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
